// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_flag,
    input  logic [31:0] req_addr,
    input  logic        discard,
    output logic        resp_flag,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_instr,
    output logic        busy,
    output logic        mem_req_flag,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_flag,
    input  logic [31:0] mem_resp_addr,
    input  logic [31:0] mem_resp_data,
`ifdef ICACHE_STAT_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic        dbg_state
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    // Handshake: IF presents req_flag/req_addr and holds them while busy=1;
    // mem_req_flag/mem_req_addr stay asserted and stable until a mem_resp_flag
    // pulse arrives whose mem_resp_addr equals mem_req_addr.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];
    logic [31:0]         r_miss_addr;
    logic                r_cancel;
    logic                r_resp_flag;
    logic [31:0]         r_resp_addr;
    logic [31:0]         r_resp_instr;

    logic [INDEX_BITS-1:0] w_idx;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_accept_hit;
    logic                  w_accept_miss;
    logic                  w_resp_flag_nxt;
    logic [31:0]           w_resp_addr_nxt;
    logic [31:0]           w_resp_instr_nxt;
    logic [31:0]           w_miss_addr_nxt;
    logic                  w_cancel_nxt;

    assign w_idx      = req_addr[INDEX_BITS+1:2];
    assign w_fill_idx = r_miss_addr[INDEX_BITS+1:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == req_addr[ADDR_W-1:INDEX_BITS+2]);
    assign w_fill     = (r_state == S_MISS) && mem_resp_flag && (mem_resp_addr == r_miss_addr);

    assign w_accept_hit  = (r_state == S_IDLE) && req_flag && !discard && w_hit;
    assign w_accept_miss = (r_state == S_IDLE) && req_flag && !discard && !w_hit;

    always_comb begin
        w_state_nxt      = r_state;
        w_resp_flag_nxt  = 1'b0;
        w_resp_addr_nxt  = r_resp_addr;
        w_resp_instr_nxt = r_resp_instr;
        w_miss_addr_nxt  = r_miss_addr;
        w_cancel_nxt     = r_cancel;
        case (r_state)
            S_IDLE: begin
                if (w_accept_hit) begin
                    w_resp_flag_nxt  = 1'b1;
                    w_resp_addr_nxt  = req_addr;
                    w_resp_instr_nxt = r_data[w_idx];
                end else if (w_accept_miss) begin
                    w_state_nxt     = S_MISS;
                    w_miss_addr_nxt = {req_addr[31:2], 2'b00};
                    w_cancel_nxt    = 1'b0;
                end
            end
            S_MISS: begin
                if (discard) begin
                    w_cancel_nxt = 1'b1;
                end
                if (w_fill) begin
                    w_state_nxt  = S_IDLE;
                    w_cancel_nxt = 1'b0;
                    // A discard on the fill edge itself also kills the response.
                    if (!r_cancel && !discard) begin
                        w_resp_flag_nxt  = 1'b1;
                        w_resp_addr_nxt  = r_miss_addr;
                        w_resp_instr_nxt = mem_resp_data;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_cancel     <= 1'b0;
            r_resp_flag  <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_miss_addr  <= w_miss_addr_nxt;
            r_cancel     <= w_cancel_nxt;
            r_resp_flag  <= w_resp_flag_nxt;
            r_resp_addr  <= w_resp_addr_nxt;
            r_resp_instr <= w_resp_instr_nxt;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage is not reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_fill_idx]  <= r_miss_addr[ADDR_W-1:INDEX_BITS+2];
            r_data[w_fill_idx] <= mem_resp_data;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_accept_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign resp_flag    = r_resp_flag;
    assign resp_addr    = r_resp_addr;
    assign resp_instr   = r_resp_instr;
    assign busy         = (r_state == S_MISS);
    assign mem_req_flag = (r_state == S_MISS);
    assign mem_req_addr = r_miss_addr;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetches against a line-level cache model.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        req_flag;
  logic [31:0] req_addr;
  logic        discard;
  logic        resp_flag;
  logic [31:0] resp_addr;
  logic [31:0] resp_instr;
  logic        busy;
  logic        mem_req_flag;
  logic [31:0] mem_req_addr;
  logic        mem_resp_flag;
  logic [31:0] mem_resp_addr;
  logic [31:0] mem_resp_data;
  logic        dbg_state;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk           (clk),
    .rst           (rst),
    .req_flag      (req_flag),
    .req_addr      (req_addr),
    .discard       (discard),
    .resp_flag     (resp_flag),
    .resp_addr     (resp_addr),
    .resp_instr    (resp_instr),
    .busy          (busy),
    .mem_req_flag  (mem_req_flag),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_flag (mem_resp_flag),
    .mem_resp_addr (mem_resp_addr),
    .mem_resp_data (mem_resp_data),
`ifdef ICACHE_STAT_EN
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int m_hits;
  int m_misses;

  // Reference model: per index, the fetch address that filled it and the word.
  logic [31:0] m_line[int];
  logic [31:0] m_word[int];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    logic [31:0] stored;
    idx = int'(a[7:2]);
    if (!m_line.exists(idx)) return 1'b0;
    stored = m_line[idx];
    return stored[17:8] == a[17:8];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_resp_flag"}, {31'd0, resp_flag}, 32'd0);
    chk({tag, "_resp_addr"}, resp_addr, 32'd0);
    chk({tag, "_resp_instr"}, resp_instr, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_req_flag"}, {31'd0, mem_req_flag}, 32'd0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
  endtask

  // One fetch. cmode: 0 none, 1 discard the cycle before the fill, 2 discard on the fill cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat_in,
                       input int cmode, input bit junk);
    logic [31:0] wa;
    int idx;
    int lat;
    bit cancel;
    wa  = {addr[31:2], 2'b00};
    idx = int'(addr[7:2]);
    lat = (cmode == 1 && lat_in == 0) ? 1 : lat_in;
    cancel = (cmode != 0);
    req_flag = 1'b1;
    req_addr = addr;
    step();
    req_flag = 1'b0;
    if (model_hit(addr)) begin
      m_hits++;
      chk("hit_resp_flag", {31'd0, resp_flag}, 32'd1);
      chk("hit_resp_addr", resp_addr, addr);
      chk("hit_resp_instr", resp_instr, m_word[idx]);
      chk("hit_mem_req_flag", {31'd0, mem_req_flag}, 32'd0);
    end else begin
      m_misses++;
      chk("miss_mem_req_flag", {31'd0, mem_req_flag}, 32'd1);
      chk("miss_mem_req_addr", mem_req_addr, wa);
      chk("miss_busy", {31'd0, busy}, 32'd1);
      chk("miss_resp_flag", {31'd0, resp_flag}, 32'd0);
      for (int k = 0; k < lat; k++) begin
        if (junk) begin
          req_flag = 1'b1;
          req_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (k == 0) begin
          mem_resp_flag = 1'b1;
          mem_resp_addr = wa ^ 32'h0000_0004;
          mem_resp_data = $urandom;
        end
        if (cmode == 1 && k == lat - 1) discard = 1'b1;
        step();
        mem_resp_flag = 1'b0;
        discard       = 1'b0;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_mem_req_flag", {31'd0, mem_req_flag}, 32'd1);
        chk("wait_mem_req_addr", mem_req_addr, wa);
        chk("wait_resp_flag", {31'd0, resp_flag}, 32'd0);
      end
      mem_resp_flag = 1'b1;
      mem_resp_addr = wa;
      mem_resp_data = data;
      if (cmode == 2) discard = 1'b1;
      step();
      mem_resp_flag = 1'b0;
      discard       = 1'b0;
      req_flag      = 1'b0;
      m_line[idx] = addr;
      m_word[idx] = data;
      chk("fill_resp_flag", {31'd0, resp_flag}, {31'd0, !cancel});
      if (!cancel) begin
        chk("fill_resp_addr", resp_addr, wa);
        chk("fill_resp_instr", resp_instr, data);
      end
      chk("fill_busy", {31'd0, busy}, 32'd0);
      chk("fill_mem_req_flag", {31'd0, mem_req_flag}, 32'd0);
    end
    step();
    chk("single_pulse", {31'd0, resp_flag}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_hits = 0;
    m_misses = 0;
    rst = 1'b1;
    req_flag = 1'b0;
    req_addr = '0;
    discard = 1'b0;
    mem_resp_flag = 1'b0;
    mem_resp_addr = '0;
    mem_resp_data = '0;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Cold miss then hit
    fetch(32'h0000_0100, 32'h00A0_0093, 2, 0, 1'b0);
    fetch(32'h0000_0100, 32'h0, 0, 0, 1'b0);

    // Four back-to-back hits
    for (int i = 0; i < 4; i++) begin
      req_flag = 1'b1;
      req_addr = 32'h0000_0100;
      step();
      m_hits++;
      chk("b2b_resp_flag", {31'd0, resp_flag}, 32'd1);
      chk("b2b_resp_instr", resp_instr, 32'h00A0_0093);
      chk("b2b_mem_req_flag", {31'd0, mem_req_flag}, 32'd0);
    end
    req_flag = 1'b0;
    step();
    chk("b2b_end", {31'd0, resp_flag}, 32'd0);
`ifdef ICACHE_STAT_EN
    chk("stat_miss_cold", miss_cnt, 32'd1);
    chk("stat_hit_cold", hit_cnt, 32'd5);
`endif

    // Discard mid-miss: line still filled, no response
    fetch(32'h0000_0300, 32'h1234_5678, 2, 1, 1'b0);
    fetch(32'h0000_0300, 32'h0, 0, 0, 1'b0);
    chk("discard_refill_instr", resp_instr, 32'h1234_5678);

    // Discard in IDLE ignores the request
    req_flag = 1'b1;
    req_addr = 32'h0000_0700;
    discard  = 1'b1;
    step();
    req_flag = 1'b0;
    discard  = 1'b0;
    chk("idle_discard_resp", {31'd0, resp_flag}, 32'd0);
    chk("idle_discard_mem", {31'd0, mem_req_flag}, 32'd0);
    chk("idle_discard_busy", {31'd0, busy}, 32'd0);

    // Reset mid-miss
    req_flag = 1'b1;
    req_addr = 32'h0000_0400;
    step();
    req_flag = 1'b0;
    chk("rstmiss_mem_req", {31'd0, mem_req_flag}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_line.delete();
    m_word.delete();
    m_hits = 0;
    m_misses = 0;
    check_all_zero("rstmiss");

    // Alias eviction: three misses on the same index
    fetch(32'h0000_0100, 32'hA1A1_0100, 1, 0, 1'b0);
    fetch(32'h0000_0200, 32'hB2B2_0200, 1, 0, 1'b0);
    fetch(32'h0000_0100, 32'hC3C3_0100, 1, 0, 1'b1);
    chk("alias_miss_count", m_misses, 3);

    // Randomized fetches, including aliasing high bits and cancels
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int r;
      int cm;
      a = ($urandom_range(0, 3) << 18) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      r = $urandom_range(0, 5);
      cm = (r == 4) ? 1 : (r == 5) ? 2 : 0;
      fetch(a, $urandom, $urandom_range(0, 3), cm, 1'($urandom_range(0, 1)));
    end

`ifdef ICACHE_STAT_EN
    chk("stat_hit_final", hit_cnt, m_hits);
    chk("stat_miss_final", miss_cnt, m_misses);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller.
- Serves IF fetch requests from local storage on a hit. On a miss, issues a single word read to the memory controller, fills the line, and returns the word to IF.
- Read-only. Data stores never pass through it.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines of one 32-bit word each).
- ADDR_W, 18, significant fetch address bits. Tag = addr[ADDR_W-1:INDEX_BITS+2]; addr[1:0] is ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; also asserted by the top when rdy_in is low.
- req_flag  in  1  IF fetch request valid.
- req_addr  in  32  IF fetch byte address, word aligned.
- discard  in  1  branch mispredict; abandons the in-flight fetch.
- resp_flag  out  1  one-cycle pulse: resp_instr is valid for resp_addr.
- resp_addr  out  32  address the response belongs to.
- resp_instr  out  32  fetched instruction word.
- busy  out  1  high while in MISS state; IF holds its request.
- mem_req_flag  out  1  word read request to the memory controller.
- mem_req_addr  out  32  word address of the read, low 2 bits zero.
- mem_resp_flag  in  1  memory controller read-done pulse.
- mem_resp_addr  in  32  address echoed with the memory controller's read data.
- mem_resp_data  in  32  assembled little-endian word from the memory controller.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid bits are cleared.
  - State goes to IDLE.
  - resp_flag, busy and mem_req_flag are 0; resp_addr, resp_instr and mem_req_addr are 0.
  - Tag and data arrays are not cleared.
  - Reset mid-miss drops the miss with no fill. The memory controller is reset by the same signal.
- Lookup: index = req_addr[INDEX_BITS+1:2]. A hit requires the valid bit set and a matching tag.
- State IDLE:
  - req_flag=1 and hit: at the next edge, resp_flag=1, resp_addr=req_addr, resp_instr=line data. Hit latency is 1 cycle, and a back-to-back hit can be accepted every cycle.
  - req_flag=1 and miss: at the next edge, go to MISS, latch the address, set busy=1, and set mem_req_flag=1 with mem_req_addr={req_addr[31:2],2'b00}.
  - req_flag=0: resp_flag=0.
  - discard=1 in IDLE: the request in that cycle is ignored; no response and no miss.
- State MISS:
  - mem_req_flag stays 1 and mem_req_addr stays stable until a matching response arrives.
  - A matching response is mem_resp_flag=1 and mem_resp_addr equals the latched address. On it, at that edge:
    - Write data and tag, and set the valid bit.
    - Drop mem_req_flag and busy; return to IDLE.
    - Unless cancelled, pulse resp_flag with the latched address and mem_resp_data. Fill-to-response latency is 1 cycle.
  - A mem_resp_flag with a non-matching address is ignored.
  - req_flag is ignored while in MISS.
- discard during MISS:
  - Sets an internal cancel bit.
  - The outstanding memory read still completes and the line is still filled, because the memory controller cannot abort.
  - resp_flag is suppressed for that fill. The cancel bit clears on the return to IDLE.
  - discard in the same cycle as the matching mem_resp_flag also suppresses the response.
- Simultaneous hit and fill: cannot occur, since requests are not accepted in MISS.
- resp_flag is never high for two cycles with the same resp_addr from a single request.
- Address wrap: the index wraps modulo 2^INDEX_BITS. Addresses differing only in tag bits alias and evict each other.

Optional Feature:
- Macro ICACHE_STAT_EN.
- When defined:
  - Adds output ports hit_cnt[31:0] and miss_cnt[31:0], both cleared by rst.
  - hit_cnt increments for each accepted IDLE hit.
  - miss_cnt increments on each IDLE-to-MISS transition, including misses later cancelled.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req_addr=0x00000100. Memory controller answers 3 cycles later with addr 0x100 and data 0x00A00093.
  - Required: mem_req_flag=1 with addr 0x100 one cycle after the request; busy=1 until the fill; resp_flag pulses once with 0x00A00093.
- Hit:
  - Stimulus: re-request 0x100.
  - Required: resp_flag the next cycle with 0x00A00093, mem_req_flag stays 0. Four back-to-back hits give four consecutive resp_flag pulses.
- Alias eviction:
  - Stimulus: fetch 0x100, then 0x200 (same index with INDEX_BITS=6), then 0x100.
  - Required: three misses. The final 0x100 miss refetches from memory.
- Discard mid-miss:
  - Stimulus: miss on 0x300, discard=1 the cycle before the memory response (data 0x12345678).
  - Required: no resp_flag. A later request for 0x300 hits with 0x12345678.
- Reset mid-miss:
  - Stimulus: miss on 0x400, rst=1 for one cycle before the response.
  - Required: all outputs 0, state IDLE. A later 0x100 request misses, because valid bits were cleared.
- ICACHE_STAT_EN:
  - Stimulus: the cold-miss and hit scenarios with the macro defined.
  - Required: miss_cnt=1, hit_cnt=5.
